// File: rtl/vector_pkg.sv
// Shared fixed-point vector types and helpers for the ray-marching pipeline.
// fp is signed Q8.24; add/sub wrap in 32 bits with no saturation.
package vector_pkg;

    typedef logic signed [31:0] fp;

    typedef struct packed {
        fp x;
        fp y;
        fp z;
    } vec3;

    typedef logic [15:0] pix_coord_t;

    localparam fp FP_ONE      = 32'sh01000000;
    localparam fp FP_MAX_DIST = 32'sh64000000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LAUNCH,
        ST_WAIT,
        ST_EMIT,
        ST_ADVANCE
    } disp_state_t;

    function automatic fp fp_add(input fp a, input fp b);
        return a + b;
    endfunction

    function automatic fp fp_sub(input fp a, input fp b);
        return a - b;
    endfunction

    // Elaboration-time only: n * step for parameter-derived constants.
    function automatic fp fp_scale(input int n, input fp step);
        return fp'(n) * step;
    endfunction

endpackage

// File: rtl/ray_dir_gen.sv
// Pixel walker: owns the x/y counters and the u/v accumulators and presents
// the primary ray direction {u, v, FOCAL}. u/v advance incrementally by
// PIX_STEP, so no multiplier is built; U0/V0 are parameter-time constants.
module ray_dir_gen
    import vector_pkg::*;
#(
    parameter int          WIDTH    = 640,
    parameter int          HEIGHT   = 480,
    parameter logic [31:0] PIX_STEP = 32'h0000CCCD,
    parameter logic [31:0] FOCAL    = 32'h01000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       step,
    output pix_coord_t x,
    output pix_coord_t y,
    output logic       last_x,
    output logic       last_y,
    output vec3        rd
);

    localparam fp          STEP   = fp'(PIX_STEP);
    localparam fp          U0     = fp_sub(fp'(0), fp_scale(WIDTH / 2, STEP));
    localparam fp          V0     = fp_scale(HEIGHT / 2, STEP);
    localparam pix_coord_t X_LAST = pix_coord_t'(WIDTH - 1);
    localparam pix_coord_t Y_LAST = pix_coord_t'(HEIGHT - 1);

    fp    u;
    fp    v;
    logic primed;

    assign last_x = (x == X_LAST);
    assign last_y = (y == Y_LAST);

    // rd.z reads as zero until the first frame so the output matches reset.
    assign rd = {u, v, (primed ? fp'(FOCAL) : fp'(0))};

    // Raster walk: reload on init, step one pixel (or wrap to next row) on step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x      <= '0;
            y      <= '0;
            u      <= '0;
            v      <= '0;
            primed <= 1'b0;
        end else if (init) begin
            x      <= '0;
            y      <= '0;
            u      <= U0;
            v      <= V0;
            primed <= 1'b1;
        end else if (step) begin
            if (!last_x) begin
                x <= x + 16'd1;
                u <= fp_add(u, STEP);
            end else if (!last_y) begin
                x <= '0;
                u <= U0;
                y <= y + 16'd1;
                v <= fp_sub(v, STEP);
            end
        end
    end

endmodule

// File: rtl/ray_dispatcher.sv
// Ray dispatcher: walks the pixel grid, launches the marcher once per pixel,
// captures the returned distance and streams it out on a valid/ready port.
// Optional watchdog: define RAY_TIMEOUT_EN to bound the wait for march_done
// (TIMEOUT cycles) and expose a sticky timeout_flag.
module ray_dispatcher
    import vector_pkg::*;
#(
    parameter int          WIDTH    = 640,
    parameter int          HEIGHT   = 480,
    parameter logic [31:0] PIX_STEP = 32'h0000CCCD,
    parameter logic [31:0] FOCAL    = 32'h01000000,
    parameter int          TIMEOUT  = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  vec3        cam_pos,
    output logic       busy,
    output logic       march_start,
    output vec3        march_ro,
    output vec3        march_rd,
    input  logic       march_done,
    input  fp          march_distance,
    output logic       pix_valid,
    input  logic       pix_ready,
    output fp          pix_data,
    output pix_coord_t pix_x,
    output pix_coord_t pix_y,
    output logic       pix_sof,
    output logic       pix_eol
`ifdef RAY_TIMEOUT_EN
    ,
    output logic       timeout_flag
`endif
);

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("ray_dispatcher: TIMEOUT must be at least 2");
    end

    disp_state_t state;
    disp_state_t state_next;

    pix_coord_t cur_x;
    pix_coord_t cur_y;
    logic       last_x;
    logic       last_y;
    logic       accept;
    logic       wait_first;
    logic       done_seen;
    logic       capture;

    ray_dir_gen #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .PIX_STEP(PIX_STEP),
        .FOCAL   (FOCAL)
    ) u_dir (
        .clk   (clk),
        .rst   (rst),
        .init  (accept),
        .step  (state == ST_ADVANCE),
        .x     (cur_x),
        .y     (cur_y),
        .last_x(last_x),
        .last_y(last_y),
        .rd    (march_rd)
    );

    assign accept = (state == ST_IDLE) && frame_start;

    // A done still high from the previous ray is visible in the first WAIT cycle.
    assign done_seen = (state == ST_WAIT) && !wait_first && march_done;

`ifdef RAY_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;

    assign timed_out = (state == ST_WAIT) && !done_seen && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign capture   = done_seen || timed_out;

    // Watchdog: counts WAIT cycles (0 in the first one) and latches a sticky flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
            if (accept) begin
                timeout_flag <= 1'b0;
            end else if (timed_out) begin
                timeout_flag <= 1'b1;
            end
        end
    end
`else
    assign capture = done_seen;
`endif

    // State register plus the first-WAIT-cycle marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_first <= 1'b0;
        end else begin
            state      <= state_next;
            wait_first <= (state == ST_LAUNCH);
        end
    end

    // Next-state decode; march_start and pix_valid are pure state decodes.
    always_comb begin
        state_next  = state;
        march_start = 1'b0;
        pix_valid   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_start) state_next = ST_SETUP;
            end
            ST_SETUP: begin
                state_next = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                march_start = 1'b1;
                state_next  = ST_WAIT;
            end
            ST_WAIT: begin
                if (capture) state_next = ST_EMIT;
            end
            ST_EMIT: begin
                pix_valid = 1'b1;
                if (pix_ready) state_next = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                state_next = (last_x && last_y) ? ST_IDLE : ST_SETUP;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Frame context and captured pixel; pix_* only change on capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            march_ro <= '0;
            pix_data <= '0;
            pix_x    <= '0;
            pix_y    <= '0;
            pix_sof  <= 1'b0;
            pix_eol  <= 1'b0;
        end else begin
            if (accept) begin
                busy     <= 1'b1;
                march_ro <= cam_pos;
            end else if ((state == ST_ADVANCE) && last_x && last_y) begin
                busy <= 1'b0;
            end
            if (capture) begin
`ifdef RAY_TIMEOUT_EN
                pix_data <= timed_out ? FP_MAX_DIST : march_distance;
`else
                pix_data <= march_distance;
`endif
                pix_x    <= cur_x;
                pix_y    <= cur_y;
                pix_sof  <= (cur_x == '0) && (cur_y == '0);
                pix_eol  <= last_x;
            end
        end
    end

endmodule
